// File: rtl/dma_ctrl_pkg.sv
// Shared types and constants for the rotating image-copy DMA controller.
// Holds the FSM state encoding, rotation codes, burst limit and transfer size.
package dma_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WR_WAIT,
        NEXT,
        FIN
    } state_t;

    localparam logic [1:0] ROT_0   = 2'd0;
    localparam logic [1:0] ROT_90  = 2'd1;
    localparam logic [1:0] ROT_180 = 2'd2;
    localparam logic [1:0] ROT_270 = 2'd3;

    localparam logic [4:0] MAX_BURST = 5'd16;
    localparam logic [2:0] SIZE_WORD = 3'b010;

    // Pixels in the next read burst: the rest of the row, capped at MAX_BURST.
    function automatic logic [4:0] burst_len(input logic [15:0] remaining);
        if (remaining > {11'd0, MAX_BURST}) begin
            return MAX_BURST;
        end
        return remaining[4:0];
    endfunction

endpackage

// File: rtl/dma_ctrl_agen.sv
// Pixel offset generator: read offsets and rotated write offsets built from
// row/column accumulators, plus a shift-add W*H computed once per job.
module dma_ctrl_agen
    import dma_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic [15:0] init_width,
    input  logic [15:0] init_height,
    input  logic [1:0]  rot,
    input  logic [15:0] x,
    input  logic [15:0] col,
    input  logic [15:0] y,
    input  logic        pixel_step,
    input  logic        row_step,
    output logic        ready,
    output logic [31:0] rd_off,
    output logic [31:0] wr_off
);

    logic [15:0] width;
    logic [15:0] height;
    logic [31:0] row_base;
    logic [31:0] col_acc;
    logic [31:0] area;
    logic [31:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] h32;
    logic [31:0] y32;
    logic [31:0] col32;
    logic [31:0] lin_off;

    // row_base tracks y*W, col_acc tracks col*H; area settles to W*H within 16 cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            width    <= 16'd0;
            height   <= 16'd0;
            row_base <= 32'd0;
            col_acc  <= 32'd0;
            area     <= 32'd0;
            mul_a    <= 32'd0;
            mul_b    <= 16'd0;
        end else if (init) begin
            width    <= init_width;
            height   <= init_height;
            row_base <= 32'd0;
            col_acc  <= 32'd0;
            area     <= 32'd0;
            mul_a    <= {16'd0, init_width};
            mul_b    <= init_height;
        end else begin
            if (mul_b != 16'd0) begin
                if (mul_b[0]) begin
                    area <= area + mul_a;
                end
                mul_a <= mul_a << 1;
                mul_b <= mul_b >> 1;
            end
            if (row_step) begin
                row_base <= row_base + {16'd0, width};
                col_acc  <= 32'd0;
            end else if (pixel_step) begin
                col_acc <= col_acc + {16'd0, height};
            end
        end
    end

    assign ready   = (mul_b == 16'd0);
    assign h32     = {16'd0, height};
    assign y32     = {16'd0, y};
    assign col32   = {16'd0, col};
    assign lin_off = row_base + col32;
    assign rd_off  = row_base + {16'd0, x};

    // Rotations mirror the linear index against W*H or walk columns in steps of H.
    always_comb begin
        wr_off = lin_off;
        case (rot)
            ROT_90:  wr_off = col_acc + h32 - 32'd1 - y32;
            ROT_180: wr_off = area - 32'd1 - lin_off;
            ROT_270: wr_off = area - h32 - col_acc + y32;
            default: wr_off = lin_off;
        endcase
    end

endmodule

// File: rtl/dma_ctrl.sv
// Image copy/rotate DMA sequencer: burst reads of a row chunk, then one write per pixel.
// Build option DMA_CTRL_ROT180_EN enables true 180-degree rotation; without it ROT=2 copies.
module dma_ctrl
    import dma_ctrl_pkg::*;
(
    input  logic        I_CTRL_HCLK,
    input  logic        I_CTRL_HRESET_N,
    input  logic        I_CTRL_START,
    input  logic [31:0] I_CTRL_SRC_ADDR,
    input  logic [31:0] I_CTRL_DST_ADDR,
    input  logic [15:0] I_CTRL_WIDTH,
    input  logic [15:0] I_CTRL_HEIGHT,
    input  logic [1:0]  I_CTRL_ROT,
    input  logic        I_CTRL_DMA_READY,
    output logic        O_CTRL_DMA_START,
    output logic [31:0] O_CTRL_DMA_ADDR,
    output logic [4:0]  O_CTRL_DMA_COUNT,
    output logic [2:0]  O_CTRL_DMA_SIZE,
    output logic        O_CTRL_DMA_WRITE,
    output logic [7:0]  O_CTRL_BUF_ADDR,
    output logic        O_CTRL_BUSY,
    output logic        O_CTRL_DONE
);

    state_t      state;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] width;
    logic [15:0] height;
    logic [1:0]  rot;
    logic [15:0] x;
    logic [15:0] y;
    logic [4:0]  burst;
    logic [4:0]  beat;
    logic [15:0] col;
    logic [4:0]  next_burst;
    logic [1:0]  start_rot;
    logic        init;
    logic        pixel_step;
    logic        row_end;
    logic        row_step;
    logic        agen_ready;
    logic [31:0] rd_off;
    logic [31:0] wr_off;

    assign col             = x + {11'd0, beat};
    assign next_burst      = burst_len(width - x);
    assign init            = (state == IDLE) && I_CTRL_START;
    assign pixel_step      = (state == WR_WAIT) && I_CTRL_DMA_READY;
    assign row_end         = ((x + {11'd0, burst}) == width);
    assign row_step        = (state == NEXT) && row_end;
    assign O_CTRL_DMA_SIZE = SIZE_WORD;

`ifdef DMA_CTRL_ROT180_EN
    assign start_rot = I_CTRL_ROT;
`else
    assign start_rot = (I_CTRL_ROT == ROT_180) ? ROT_0 : I_CTRL_ROT;
`endif

    dma_ctrl_agen agen (
        .clk         (I_CTRL_HCLK),
        .rst_n       (I_CTRL_HRESET_N),
        .init        (init),
        .init_width  (I_CTRL_WIDTH),
        .init_height (I_CTRL_HEIGHT),
        .rot         (rot),
        .x           (x),
        .col         (col),
        .y           (y),
        .pixel_step  (pixel_step),
        .row_step    (row_step),
        .ready       (agen_ready),
        .rd_off      (rd_off),
        .wr_off      (wr_off)
    );

    always_ff @(posedge I_CTRL_HCLK) begin
        if (!I_CTRL_HRESET_N) begin
            state            <= IDLE;
            src              <= 32'd0;
            dst              <= 32'd0;
            width            <= 16'd0;
            height           <= 16'd0;
            rot              <= ROT_0;
            x                <= 16'd0;
            y                <= 16'd0;
            burst            <= 5'd0;
            beat             <= 5'd0;
            O_CTRL_DMA_START <= 1'b0;
            O_CTRL_DMA_ADDR  <= 32'd0;
            O_CTRL_DMA_COUNT <= 5'd0;
            O_CTRL_DMA_WRITE <= 1'b0;
            O_CTRL_BUF_ADDR  <= 8'd0;
            O_CTRL_BUSY      <= 1'b0;
            O_CTRL_DONE      <= 1'b0;
        end else begin
            O_CTRL_DMA_START <= 1'b0;
            O_CTRL_DONE      <= 1'b0;
            case (state)
                IDLE: begin
                    if (I_CTRL_START) begin
                        src         <= I_CTRL_SRC_ADDR;
                        dst         <= I_CTRL_DST_ADDR;
                        width       <= I_CTRL_WIDTH;
                        height      <= I_CTRL_HEIGHT;
                        rot         <= start_rot;
                        x           <= 16'd0;
                        y           <= 16'd0;
                        beat        <= 5'd0;
                        O_CTRL_BUSY <= 1'b1;
                        state       <= (I_CTRL_WIDTH == 16'd0 || I_CTRL_HEIGHT == 16'd0) ? FIN : RD_REQ;
                    end
                end
                RD_REQ: begin
                    O_CTRL_DMA_START <= 1'b1;
                    O_CTRL_DMA_WRITE <= 1'b0;
                    O_CTRL_DMA_ADDR  <= src + (rd_off << 2);
                    O_CTRL_DMA_COUNT <= next_burst;
                    burst            <= next_burst;
                    state            <= RD_WAIT;
                end
                RD_WAIT: begin
                    if (I_CTRL_DMA_READY) begin
                        beat  <= 5'd0;
                        state <= WR_REQ;
                    end
                end
                // The first write of a job may wait here until W*H has settled.
                WR_REQ: begin
                    if (agen_ready) begin
                        O_CTRL_DMA_START <= 1'b1;
                        O_CTRL_DMA_WRITE <= 1'b1;
                        O_CTRL_DMA_COUNT <= 5'd1;
                        O_CTRL_BUF_ADDR  <= {3'd0, beat};
                        O_CTRL_DMA_ADDR  <= dst + (wr_off << 2);
                        state            <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (I_CTRL_DMA_READY) begin
                        if ((beat + 5'd1) < burst) begin
                            beat  <= beat + 5'd1;
                            state <= WR_REQ;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                NEXT: begin
                    beat <= 5'd0;
                    if (row_end) begin
                        x     <= 16'd0;
                        y     <= y + 16'd1;
                        state <= ((y + 16'd1) == height) ? FIN : RD_REQ;
                    end else begin
                        x     <= x + {11'd0, burst};
                        state <= RD_REQ;
                    end
                end
                FIN: begin
                    O_CTRL_DONE <= 1'b1;
                    O_CTRL_BUSY <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 SHALL have port I_CTRL_HCLK, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port I_CTRL_HRESET_N, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port I_CTRL_START, input, 1 bit: one-cycle job request.
REQ-004 SHALL have ports I_CTRL_SRC_ADDR and I_CTRL_DST_ADDR, input, 32 bits each: word-aligned image base addresses.
REQ-005 SHALL have ports I_CTRL_WIDTH and I_CTRL_HEIGHT, input, 16 bits each: source size in pixels (one 32-bit word per pixel).
REQ-006 SHALL have port I_CTRL_ROT, input, 2 bits: 0 copy, 1 rotate 90 CW, 2 rotate 180, 3 rotate 270 CW.
REQ-007 SHALL have port I_CTRL_DMA_READY, input, 1 bit: one-cycle pulse from the dma block marking completion of the last issued command.
REQ-008 SHALL have port O_CTRL_DMA_START, output, 1 bit: one-cycle command strobe to the dma block.
REQ-009 SHALL have ports O_CTRL_DMA_ADDR (32 bits), O_CTRL_DMA_COUNT (5 bits), O_CTRL_DMA_SIZE (3 bits) and O_CTRL_DMA_WRITE (1 bit), outputs: command fields.
REQ-010 SHALL have port O_CTRL_BUF_ADDR, output, 8 bits: input-buffer pixel index for the current write.
REQ-011 SHALL have port O_CTRL_BUSY, output, 1 bit: job active.
REQ-012 SHALL have port O_CTRL_DONE, output, 1 bit: one-cycle pulse at job end.

Function
REQ-013 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT and FIN.
REQ-014 SHALL, in IDLE on I_CTRL_START=1, register all configuration inputs, clear x/y counters, and enter RD_REQ next cycle; O_CTRL_BUSY=1 from that cycle.
REQ-015 SHALL, in RD_REQ, pulse O_CTRL_DMA_START for one cycle with WRITE=0, ADDR=SRC+4*(y*W+x), COUNT=C=min(16,W-x) (16 encoded as 5'd16), then enter RD_WAIT.
REQ-016 SHALL, in RD_WAIT, hold until I_CTRL_DMA_READY=1, then enter WR_REQ with beat index k=0.
REQ-017 SHALL, in WR_REQ, pulse O_CTRL_DMA_START with WRITE=1, COUNT=1, BUF_ADDR=k, ADDR=DST+4*off, off per pixel (x+k, y): rot0 y*W+x+k; rot1 (x+k)*H+H-1-y; rot2 (H-1-y)*W+W-1-x-k; rot3 (W-1-x-k)*H+y.
REQ-018 SHALL, in WR_WAIT on I_CTRL_DMA_READY, increment k, return to WR_REQ if k<C, else enter NEXT.
REQ-019 SHALL, in NEXT, advance x by C; on x=W set x=0 and y+1; on y=H enter FIN, else enter RD_REQ.
REQ-020 SHALL, in FIN, pulse O_CTRL_DONE one cycle, clear O_CTRL_BUSY, and return to IDLE.
REQ-021 SHALL drive O_CTRL_DMA_SIZE=3'b010 constantly.
REQ-022 SHALL hold command fields stable from the START strobe until the matching I_CTRL_DMA_READY.
REQ-023 SHALL compute all address arithmetic modulo 2^32, with no overflow flag.
REQ-024 SHALL ignore I_CTRL_START while O_CTRL_BUSY=1.
REQ-025 SHALL ignore I_CTRL_DMA_READY outside RD_WAIT and WR_WAIT.
REQ-026 SHALL, on a job with W=0 or H=0, go IDLE->FIN directly with no dma command.

Reset
REQ-027 SHALL, while I_CTRL_HRESET_N=0 at a clock edge, enter IDLE and zero every output and counter, including in mid-job; no command is pending afterwards.

Configuration
REQ-028 SHALL, with DMA_CTRL_ROT180_EN defined, implement rotation 180 as in REQ-017.
REQ-029 SHALL, without DMA_CTRL_ROT180_EN, treat I_CTRL_ROT=2 as rotation 0 (copy).

Structure
REQ-030 SHALL take FSM state encodings, ROT codes, max burst (16) and SIZE_WORD (3'b010) from shared package dma_ctrl_pkg.
REQ-031 SHALL place offset computation in sub-module dma_ctrl_agen, using incremental row/column accumulators; no general multiplier.

Verification
REQ-032 SHALL verify: W=4, H=2, ROT=0, SRC=0x1000, DST=0x2000 -> reads at 0x1000/0x1010 with COUNT=4; writes 0x2000..0x201C in order; one DONE pulse.
REQ-033 SHALL verify: W=2, H=3, ROT=1, DST=0x0 -> first row writes at 0x8 then 0x14; final write at 0x0C.
REQ-034 SHALL verify: W=20, H=1 -> reads COUNT=16 at SRC, then COUNT=4 at SRC+0x40; 20 writes total.
REQ-035 SHALL verify: W=0, H=5 -> no DMA_START; DONE exactly 2 cycles after START.
REQ-036 SHALL verify: reset asserted during WR_WAIT -> all outputs 0 next cycle; a new START runs a clean job; a START while busy has no effect.
REQ-037 SHALL verify: ROT=2, W=2, H=2, DST=0 -> first write 0xC with macro defined, 0x0 with it undefined.
